// File: rtl/packer_pkg.sv
// Shared constants and types for the quad-word packer that feeds the
// four-input signed adder.
package packer_pkg;

    // Width of every data word (signed, two's complement).
    localparam int WIDTH = 25;

    // Words per frame; the adder has exactly four word inputs.
    localparam int LANES = 4;

    // Fill count spans 0..LANES, so it needs one bit more than a lane index.
    localparam int FC_W = 3;

    // Width of the delivered-frame counter.
    localparam int FRAME_COUNT_W = 16;

    typedef logic signed [WIDTH-1:0] word_t;

endpackage : packer_pkg

// File: rtl/quad_word_packer.sv
// Packs a serial stream of signed words into four-word frames for the
// adder. A fill buffer collects the next frame while the output buffer
// holds the previous one for the consumer, giving one word per clock
// sustained throughput.
//
// Handshakes: a word moves on any rising edge where in_valid_i and
// in_ready_o are both high; a frame moves on any rising edge where
// out_valid_o and out_ready_i are both high. in_ready_o depends only on
// registered state and reset, never on out_ready_i. Once out_valid_o
// rises, it and word_*_o stay put until the frame moves.
module quad_word_packer
    import packer_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         word_0_o,
    output logic [WIDTH-1:0]         word_1_o,
    output logic [WIDTH-1:0]         word_2_o,
    output logic [WIDTH-1:0]         word_3_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [FRAME_COUNT_W-1:0] frame_count_o,
    output logic [FC_W-1:0]          fill_count_o
);

    localparam logic [FC_W-1:0] FC_FULL = FC_W'(LANES);

    // Fill buffer: lanes plus count of lanes already written (0..4).
    word_t                    fill_q [LANES];
    word_t                    fill_d [LANES];
    logic [FC_W-1:0]          fc_q;
    logic [FC_W-1:0]          fc_d;

    // Output buffer presented to the adder.
    word_t                    word_q [LANES];
    word_t                    word_d [LANES];
    logic                     out_valid_q;
    logic                     out_valid_d;

    logic [FRAME_COUNT_W-1:0] frame_count_q;
    logic [FRAME_COUNT_W-1:0] frame_count_d;

    // Per-edge decode.
    logic                     accept;
    logic                     fire;
    logic                     out_free;
    logic                     pad;
    logic                     complete;
    logic [FC_W-1:0]          cnt_acc;

    // Room for a word whenever the fill buffer is not holding a finished frame.
    assign in_ready_o = rst_n_i && (fc_q < FC_FULL);

    // Next-state for both buffers: accept first, then padding, then hand-off.
    always_comb begin
        accept        = in_valid_i && in_ready_o;
        fire          = out_valid_q && out_ready_i;
        out_free      = !out_valid_q || out_ready_i;

        for (int i = 0; i < LANES; i++) begin
            fill_d[i] = fill_q[i];
            word_d[i] = word_q[i];
        end

        // Count after this edge's accept; the new word lands before padding.
        cnt_acc = fc_q;
        if (accept) begin
            fill_d[fc_q[1:0]] = word_t'(in_data_i);
            cnt_acc           = fc_q + FC_W'(1);
        end

        // Flush only closes a frame that has at least one word and is not
        // already full; an empty or already-complete buffer ignores it.
        pad = flush_i && (cnt_acc != '0) && (cnt_acc != FC_FULL);
        if (pad) begin
            for (int i = 0; i < LANES; i++) begin
                if (FC_W'(i) >= cnt_acc) begin
                    fill_d[i] = '0;
                end
            end
        end

        complete      = (cnt_acc == FC_FULL) || pad;

        fc_d          = cnt_acc;
        out_valid_d   = out_valid_q && !out_ready_i;
        frame_count_d = frame_count_q + FRAME_COUNT_W'(fire);

        if (complete) begin
            if (out_free) begin
                for (int i = 0; i < LANES; i++) begin
                    word_d[i] = fill_d[i];
                end
                out_valid_d = 1'b1;
                fc_d        = '0;
            end else begin
                // Park the finished (possibly padded) frame until the
                // output buffer frees up.
                fc_d = FC_FULL;
            end
        end
    end

    // State registers; reset discards partial and pending frames.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < LANES; i++) begin
                fill_q[i] <= '0;
                word_q[i] <= '0;
            end
            fc_q          <= '0;
            out_valid_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                fill_q[i] <= fill_d[i];
                word_q[i] <= word_d[i];
            end
            fc_q          <= fc_d;
            out_valid_q   <= out_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign word_0_o      = word_q[0];
    assign word_1_o      = word_q[1];
    assign word_2_o      = word_q[2];
    assign word_3_o      = word_q[3];
    assign out_valid_o   = out_valid_q;
    assign frame_count_o = frame_count_q;
    assign fill_count_o  = fc_q;

endmodule : quad_word_packer
